alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_pkg.sv | 11 +
 rtl/alu_exec_core.sv | 39 +++
 rtl/alu_exec_unit.sv | 120 ++++++++++++
 tb/tb_alu_exec_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: operation codes and FSM state type shared by the ALU execution unit.
package alu_exec_pkg;
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_LUI  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
endpackage

// File: rtl/alu_exec_core.sv
// alu_exec_core: combinational ALU datapath; ALU_EXEC_OVF_EN adds signed-overflow detection.
module alu_exec_core import alu_exec_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  err
`ifdef ALU_EXEC_OVF_EN
  ,output logic                 ovf
`endif
);
  logic [DATA_WIDTH-1:0] sum, diff;
  assign sum  = a + b;
  assign diff = a - b;
  always_comb begin
    err = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOR:  result = ~(a | b);
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      OP_LUI:  result = b << 16;
      OP_PASS: result = a;
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
  end
`ifdef ALU_EXEC_OVF_EN
  localparam int M = DATA_WIDTH - 1;
  // Signed overflow: operands of matching (ADD) / differing (SUB) sign with a sign flip in the result.
  assign ovf = (op == OP_ADD) ? (a[M] == b[M]) && (sum[M] != a[M]) :
               (op == OP_SUB) ? (a[M] != b[M]) && (diff[M] != a[M]) : 1'b0;
`endif
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU with a one-bit-per-cycle logical shifter and registered results.
// Defining ALU_EXEC_OVF_EN adds a registered signed-overflow output for ADD/SUB.
module alu_exec_unit import alu_exec_pkg::*; #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             alu_operation,
  input  logic                   shift_en,
  input  logic                   shift_right,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [DATA_WIDTH-1:0]  read_data_1,
  input  logic [DATA_WIDTH-1:0]  read_data_2,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  alu_result,
  output logic                   zero,
  output logic                   op_err
`ifdef ALU_EXEC_OVF_EN
  ,output logic                  overflow
`endif
);
  state_e                 state_q, state_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  sh_q, sh_d, result_q, result_d, core_result;
  logic                   dir_q, dir_d, zero_q, zero_d, err_q, err_d, core_err;
`ifdef ALU_EXEC_OVF_EN
  logic                   ovf_q, ovf_d, core_ovf;
`endif

  alu_exec_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .op     (alu_operation),
    .a      (read_data_1),
    .b      (read_data_2),
    .result (core_result),
    .err    (core_err)
`ifdef ALU_EXEC_OVF_EN
    ,.ovf   (core_ovf)
`endif
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    dir_d    = dir_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
`ifdef ALU_EXEC_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        err_d = !shift_en && core_err;
`ifdef ALU_EXEC_OVF_EN
        ovf_d = !shift_en && core_ovf;
`endif
        // Multi-cycle shifts keep the previous result visible until they complete.
        if (shift_en && shamt != '0) begin
          state_d = S_SHIFT;
          sh_d    = read_data_1;
          cnt_d   = shamt;
          dir_d   = shift_right;
        end else begin
          state_d  = S_DONE;
          result_d = shift_en ? read_data_1 : core_result;
          zero_d   = result_d == '0;
        end
      end
      S_SHIFT: begin
        sh_d  = dir_q ? sh_q >> 1 : sh_q << 1;
        cnt_d = cnt_q - SHAMT_WIDTH'(1);
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          state_d  = S_DONE;
          result_d = sh_d;
          zero_d   = sh_d == '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      dir_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_EXEC_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      dir_q    <= dir_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
`ifdef ALU_EXEC_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = state_q != S_IDLE;
  assign done       = state_q == S_DONE;
  assign alu_result = result_q;
  assign zero       = zero_q;
  assign op_err     = err_q;
`ifdef ALU_EXEC_OVF_EN
  assign overflow   = ovf_q;
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench; expected results queued at start, checked on done.
module tb_alu_exec_unit;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, shift_en = 1'b0, shift_right = 1'b0;
  logic [2:0]  alu_operation = 3'b0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] read_data_1 = '0, read_data_2 = '0, alu_result;
  logic        busy, done, zero, op_err;
`ifdef ALU_EXEC_OVF_EN
  logic        overflow;
`endif

  typedef struct {
    logic [31:0] res;
    logic        z, err, ovf;
    int          lat, t0;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0, n_err = 0, cyc = 0;
  logic [31:0] last_res = '0;

  alu_exec_unit dut (
    .clk(clk), .reset(reset), .start(start), .alu_operation(alu_operation),
    .shift_en(shift_en), .shift_right(shift_right), .shamt(shamt),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .busy(busy), .done(done), .alu_result(alu_result), .zero(zero), .op_err(op_err)
`ifdef ALU_EXEC_OVF_EN
    ,.overflow(overflow)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic sh, input logic right, input logic [2:0] op,
                                 input logic [4:0] n, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint s, lim;
    lim   = 64'sd2147483648;
    e.err = 1'b0;
    e.ovf = 1'b0;
    e.lat = 1;
    e.t0  = 0;
    if (sh) begin
      e.res = right ? a >> n : a << n;
      e.lat = int'(n) + 1;
    end else begin
      case (op)
        3'd0: e.res = a & b;
        3'd1: e.res = a | b;
        3'd2: e.res = ~(a | b);
        3'd3: e.res = a + b;
        3'd4: e.res = a - b;
        3'd5: e.res = {b[15:0], 16'h0};
        3'd6: e.res = a;
        default: begin e.res = 32'h0; e.err = 1'b1; end
      endcase
      s = (op == 3'd4) ? longint'($signed(a)) - longint'($signed(b))
                       : longint'($signed(a)) + longint'($signed(b));
      if (op == 3'd3 || op == 3'd4) e.ovf = (s >= lim) || (s < -lim);
    end
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && done) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("result", alu_result, e.res);
        chk("zero", zero, e.z);
        chk("op_err", op_err, e.err);
`ifdef ALU_EXEC_OVF_EN
        chk("overflow", overflow, e.ovf);
`endif
        chk("latency", cyc - e.t0 + 1, e.lat);
        last_res = e.res;
      end
    end
  end

  // Called at a negedge; returns at the first negedge the unit is idle again.
  task automatic run_op(input logic sh, input logic right, input logic [2:0] op, input logic [4:0] n,
                        input logic [31:0] a, input logic [31:0] b, input logic poke);
    exp_t e;
    bit   ok;
    shift_en = sh; shift_right = right; alu_operation = op; shamt = n;
    read_data_1 = a; read_data_2 = b; start = 1'b1;
    e    = model(sh, right, op, n, a, b);
    e.t0 = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    shift_en = 1'($urandom); shift_right = 1'($urandom); alu_operation = 3'($urandom);
    shamt = 5'($urandom); read_data_1 = $urandom; read_data_2 = $urandom;
    chk("busy_after_start", busy, 1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin ok = 1; break; end
      start = poke && !done;
      @(negedge clk);
    end
    start = 1'b0;
    if (!ok) chk("timeout", 1, 0);
    chk("hold_result", alu_result, last_res);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_result", alu_result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_op_err", op_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    run_op(0, 0, 3'd3, 0, 32'h7FFF_FFFF, 32'h1, 0);
    run_op(0, 0, 3'd4, 0, 32'h1234, 32'h1234, 0);
    run_op(0, 0, 3'd0, 0, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    run_op(0, 0, 3'd1, 0, 32'hF000_0001, 32'h0000_1230, 0);
    run_op(0, 0, 3'd2, 0, 32'hF000_0001, 32'h0000_1230, 0);
    run_op(0, 0, 3'd5, 0, 32'h1111_1111, 32'h5555_BEEF, 0);
    run_op(0, 0, 3'd6, 0, 32'hCAFE_F00D, 32'h0, 0);
    run_op(0, 0, 3'd3, 0, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(0, 0, 3'd4, 0, 32'h0, 32'h1, 0);
    run_op(0, 0, 3'd4, 0, 32'h8000_0000, 32'h1, 0);
    run_op(1, 0, 3'd0, 31, 32'h1, 32'h0, 1);
    run_op(1, 1, 3'd0, 0, 32'hF0F0_F0F0, 32'h0, 0);
    run_op(0, 0, 3'd7, 0, 32'h1234, 32'h5678, 0);
    run_op(0, 0, 3'd6, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 24; i++)
      run_op(($urandom_range(0, 2) == 0), 1'($urandom), 3'($urandom), 5'($urandom_range(0, 6)),
             $urandom, $urandom, 1'($urandom));
    shift_en = 1'b1; shift_right = 1'b1; shamt = 5'd8; read_data_1 = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_shift_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", alu_result, 0);
    chk("abort_zero", zero, 0);
    chk("abort_op_err", op_err, 0);
`ifdef ALU_EXEC_OVF_EN
    chk("abort_overflow", overflow, 0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_after_abort", busy, 0);
    last_res = 32'h0;
    run_op(0, 0, 3'd5, 0, 32'h0, 32'h0000_ABCD, 0);
    repeat (3) @(negedge clk);
    chk("pending", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
